data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Memory-side responder for the CPU data-memory interface. It services the CPU's memRead/memWrite requests with configurable wait states and signals completion with a one-cycle memReady pulse.
- Word-organised synchronous RAM with address-alignment and range checking.
- Sits between the CPU data port and storage; replaces the zero-latency data memory in multicycle-timing builds.

Parameters:
- ADDR_BITS, 8, log2 of word count (256 words).
- LATENCY, 2, wait cycles inserted between request acceptance and response (0..15).
- DATA_WIDTH, 32, word width in bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- address  input  32  byte address from CPU.
- dataIn  input  DATA_WIDTH  write data from CPU.
- memRead  input  1  read request, held by CPU until memReady.
- memWrite  input  1  write request, held by CPU until memReady.
- dataOut  output  DATA_WIDTH  read data; valid when memReady is high.
- memReady  output  1  one-cycle completion pulse.
- memError  output  1  high with memReady when the request was rejected.
- busy  output  1  high from acceptance until the response cycle ends.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, dataOut=0, memReady=0, memError=0, busy=0, wait counter=0. RAM contents are not cleared.
- Reset asserted mid-transaction aborts it. A pending write is not performed. No memReady is issued.
- FSM states:
  - IDLE: on a clk edge with memRead or memWrite high, capture address, dataIn and request type; go to WAIT if LATENCY>0, else RESPOND. busy=1 from the next cycle.
  - WAIT: count LATENCY cycles, then go to RESPOND. Input changes are ignored, because the captured values are used.
  - RESPOND: memReady=1 for exactly one cycle, then return to IDLE.
- Latency: for an acceptance edge at cycle k, memReady is high during cycle k+LATENCY+1.
- The write commits to RAM on the edge entering RESPOND. A read loads dataOut on the same edge. dataOut holds its value until the next successful read.
- memRead and memWrite both high at acceptance: treated as an error. No RAM update; dataOut is unchanged; memError=1 with memReady.
- Word index = address[ADDR_BITS+1:2].
- Misaligned address (address[1:0]!=0): error. No write; dataOut is unchanged.
- Out of range (address[31:ADDR_BITS+2] != 0): error. No write; dataOut is forced to 0.
- memError is meaningful only while memReady is high and is 0 otherwise.
- A request still held in the cycle after memReady is accepted as a new transaction. The CPU must drop its request on seeing memReady to avoid a repeat.
- Request dropped during WAIT: the transaction still completes and memReady still pulses.
- Back-to-back requests: minimum period LATENCY+2 cycles (the IDLE cycle is mandatory).
- Wait counter is 4 bits and never wraps; LATENCY>15 is illegal.

Optional Feature:
- Macro MEM_ACCESS_COUNT_EN.
- Defined: adds outputs readCount[15:0] and writeCount[15:0].
  - Each increments on the response edge of a successful read or write.
  - Errors do not count. Counts saturate at 16'hFFFF. Both reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Write then read, LATENCY=2: write 0xDEADBEEF to address 0x10; memReady at acceptance+3. Read 0x10 → dataOut=0xDEADBEEF, memError=0, memReady high exactly 1 cycle.
- Misaligned write to 0x13 with 0x12345678 → memError=1 with memReady. A following read of 0x10 still returns 0xDEADBEEF.
- Read of 0x00000400 (out of range, ADDR_BITS=8) → memReady with memError=1, dataOut=0.
- memRead=memWrite=1 at 0x20 → memError=1; a later read of 0x20 shows its prior contents unchanged.
- reset driven low during WAIT of a write of 0xCAFEF00D to 0x30:
  - Outputs go to 0 immediately with no memReady.
  - After release, a read of 0x30 does not return 0xCAFEF00D (prior value preserved).
- With MEM_ACCESS_COUNT_EN: 3 good reads, 2 good writes and 1 error → readCount=3, writeCount=2. LATENCY=0 build: memReady in the cycle after acceptance.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with configurable wait states, alignment/range checks and a one-cycle ready pulse.
// Optional MEM_ACCESS_COUNT_EN adds saturating readCount/writeCount outputs.
module data_mem_responder #(
  parameter int unsigned ADDR_BITS  = 8,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  memRead,
  input  logic                  memWrite,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  memReady,
  output logic                  memError,
  output logic                  busy
`ifdef MEM_ACCESS_COUNT_EN
  ,
  output logic [15:0]           readCount,
  output logic [15:0]           writeCount
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;

  localparam logic [3:0] LAST_WAIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t                state, next_state;
  logic [3:0]            cnt;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  rd_q, wr_q, err_q;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  logic [31:0]           cur_addr;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  cur_rd, cur_wr;
  logic                  misaligned, out_of_range, req_err, commit;
  logic [ADDR_BITS-1:0]  idx;

  // With zero latency the commit edge is the acceptance edge, so the live inputs are used.
  always_comb begin
    cur_addr     = (state == S_IDLE) ? address  : addr_q;
    cur_data     = (state == S_IDLE) ? dataIn   : data_q;
    cur_rd       = (state == S_IDLE) ? memRead  : rd_q;
    cur_wr       = (state == S_IDLE) ? memWrite : wr_q;
    misaligned   = |cur_addr[1:0];
    out_of_range = |cur_addr[31:ADDR_BITS+2];
    req_err      = (cur_rd & cur_wr) | misaligned | out_of_range;
    idx          = cur_addr[ADDR_BITS+1:2];

    next_state = state;
    case (state)
      S_IDLE:    if (memRead || memWrite) next_state = (LATENCY == 0) ? S_RESPOND : S_WAIT;
      S_WAIT:    if (cnt == LAST_WAIT) next_state = S_RESPOND;
      S_RESPOND: next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
    commit = (next_state == S_RESPOND) && (state != S_RESPOND);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      dataOut <= '0;
    end else begin
      state <= next_state;
      if (state == S_IDLE) begin
        addr_q <= address;
        data_q <= dataIn;
        rd_q   <= memRead;
        wr_q   <= memWrite;
        cnt    <= '0;
      end else if (state == S_WAIT && cnt != LAST_WAIT) begin
        cnt <= cnt + 4'd1;
      end
      if (commit) begin
        err_q <= req_err;
        if (out_of_range)
          dataOut <= '0;
        else if (!req_err && cur_rd)
          dataOut <= mem[idx];
      end
    end
  end

  // RAM has no reset; the reset qualifier keeps an aborted write from landing.
  always_ff @(posedge clk) begin
    if (commit && reset && !req_err && cur_wr)
      mem[idx] <= cur_data;
  end

`ifdef MEM_ACCESS_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readCount  <= '0;
      writeCount <= '0;
    end else if (commit && !req_err) begin
      if (cur_rd && readCount != '1)
        readCount <= readCount + 16'd1;
      if (cur_wr && writeCount != '1)
        writeCount <= writeCount + 16'd1;
    end
  end
`endif

  assign memReady = (state == S_RESPOND);
  assign memError = memReady & err_q;
  assign busy     = (state != S_IDLE);

endmodule
